// File: rtl/multi_gated_clk_ctrl.sv
// N-channel clock-gate controller: per-channel OFF/WAKE/ON/HOLD FSM with wake-up
// ack delay and idle hysteresis, driving a latch-based gate cell per channel.
//   state | meaning
//   OFF   | gate closed, ack low
//   WAKE  | gate open, clock running for WAKE_CYC cycles before ack
//   ON    | gate open, ack high, request active
//   HOLD  | gate open, ack high, idle countdown after request dropped
module multi_gated_clk_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2,
    parameter int IDLE_CYC = 16
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              global_en,
    input  logic [NUM_CH-1:0] module_en,
    input  logic [NUM_CH-1:0] local_en,
    input  logic [NUM_CH-1:0] external_en,
    input  logic              pad_yy_test_mode,
    input  logic              pad_yy_gate_clk_en_b,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_ack,
    output logic [NUM_CH-1:0] clk_gate_en
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [CNT_W-1:0] WAKE_LD = (WAKE_CYC > 0) ? CNT_W'(WAKE_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] IDLE_LD = (IDLE_CYC > 0) ? CNT_W'(IDLE_CYC - 1) : '0;

`ifndef FPGA
    logic se;
    assign se = pad_yy_test_mode | pad_yy_gate_clk_en_b;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             req;

        assign req = (global_en & (module_en[i] | local_en[i])) | external_en[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_OFF: begin
                    if (req) begin
                        if (WAKE_CYC > 0) begin
                            state_d = ST_WAKE;
                            cnt_d   = WAKE_LD;
                        end else begin
                            state_d = ST_ON;
                        end
                    end
                end
                // a dropped request is ignored here; wake always completes
                ST_WAKE: begin
                    if (cnt_q == '0) state_d = ST_ON;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                ST_ON: begin
                    if (!req) begin
                        if (IDLE_CYC > 0) begin
                            state_d = ST_HOLD;
                            cnt_d   = IDLE_LD;
                        end else begin
                            state_d = ST_OFF;
                        end
                    end
                end
                ST_HOLD: begin
                    if (req)                state_d = ST_ON;
                    else if (cnt_q == '0)   state_d = ST_OFF;
                    else                    cnt_d   = cnt_q - 1'b1;
                end
                default: state_d = ST_OFF;
            endcase
        end

        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                state_q <= ST_OFF;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign clk_gate_en[i] = (state_q != ST_OFF);
        assign clk_ack[i]     = (state_q == ST_ON) || (state_q == ST_HOLD);

`ifdef FPGA
        assign clk_out[i] = clk_in;
`else
        // latch is transparent while clk_in is low so the enable cannot glitch the high phase
        logic en_lat;
        always_latch begin
            if (!clk_in) en_lat = clk_gate_en[i] | se;
        end
        assign clk_out[i] = clk_in & en_lat;
`endif
    end

endmodule

// File: tb/tb_multi_gated_clk_ctrl.sv
// Directed bench for multi_gated_clk_ctrl: default instance plus two instances with
// alternative wake/idle settings, all sharing the same stimulus.
module tb_multi_gated_clk_ctrl;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       global_en = 1'b0;
    logic [3:0] module_en = '0;
    logic [3:0] local_en = '0;
    logic [3:0] external_en = '0;
    logic       pad_yy_test_mode = 1'b0;
    logic       pad_yy_gate_clk_en_b = 1'b0;

    logic [3:0] clk_out, clk_ack, clk_gate_en;
    logic [3:0] z_clk_out, z_clk_ack, z_clk_gate_en;
    logic [3:0] w_clk_out, w_clk_ack, w_clk_gate_en;

    int total = 0;
    int bad = 0;

    always #5 clk_in = ~clk_in;

    multi_gated_clk_ctrl #(.NUM_CH(4), .CNT_W(8), .WAKE_CYC(2), .IDLE_CYC(16)) dut (
        .clk_in(clk_in), .rst(rst), .global_en(global_en), .module_en(module_en),
        .local_en(local_en), .external_en(external_en), .pad_yy_test_mode(pad_yy_test_mode),
        .pad_yy_gate_clk_en_b(pad_yy_gate_clk_en_b), .clk_out(clk_out), .clk_ack(clk_ack),
        .clk_gate_en(clk_gate_en));

    multi_gated_clk_ctrl #(.NUM_CH(4), .CNT_W(8), .WAKE_CYC(0), .IDLE_CYC(0)) dut_z (
        .clk_in(clk_in), .rst(rst), .global_en(global_en), .module_en(module_en),
        .local_en(local_en), .external_en(external_en), .pad_yy_test_mode(pad_yy_test_mode),
        .pad_yy_gate_clk_en_b(pad_yy_gate_clk_en_b), .clk_out(z_clk_out), .clk_ack(z_clk_ack),
        .clk_gate_en(z_clk_gate_en));

    multi_gated_clk_ctrl #(.NUM_CH(4), .CNT_W(8), .WAKE_CYC(3), .IDLE_CYC(4)) dut_w3 (
        .clk_in(clk_in), .rst(rst), .global_en(global_en), .module_en(module_en),
        .local_en(local_en), .external_en(external_en), .pad_yy_test_mode(pad_yy_test_mode),
        .pad_yy_gate_clk_en_b(pad_yy_gate_clk_en_b), .clk_out(w_clk_out), .clk_ack(w_clk_ack),
        .clk_gate_en(w_clk_gate_en));

    // advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        global_en = 1'b0; module_en = '0; local_en = '0; external_en = '0;
        pad_yy_test_mode = 1'b0; pad_yy_gate_clk_en_b = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick(1);
            total++;
            if (clk_gate_en !== 4'h0 || clk_ack !== 4'h0) begin
                bad++;
                $display("FAIL reset_idle got gate=%h ack=%h exp gate=0 ack=0", clk_gate_en, clk_ack);
            end
            total++;
            if (clk_out !== 4'h0) begin
                bad++;
                $display("FAIL reset_clk_out_high_phase got=%h exp=0", clk_out);
            end
        end
    endtask

    // inputs driven just after edge A are first sampled at A+1
    task automatic test_wake();
        do_reset();
        global_en = 1'b1; module_en = 4'b0001;
        tick(1);
        total++;
        if (clk_gate_en !== 4'b0001 || clk_ack !== 4'h0) begin
            bad++;
            $display("FAIL wake_gate_rise got gate=%h ack=%h exp gate=1 ack=0", clk_gate_en, clk_ack);
        end
        tick(1);
        total++;
        if (clk_ack !== 4'h0) begin
            bad++;
            $display("FAIL wake_ack_early got=%h exp=0", clk_ack);
        end
        total++;
        if (clk_out !== 4'b0001) begin
            bad++;
            $display("FAIL wake_clk_out_running got=%h exp=1", clk_out);
        end
        tick(1);
        total++;
        if (clk_ack !== 4'b0001 || clk_gate_en !== 4'b0001) begin
            bad++;
            $display("FAIL wake_ack_rise got gate=%h ack=%h exp gate=1 ack=1", clk_gate_en, clk_ack);
        end
    endtask

    task automatic test_idle();
        module_en = 4'b0000;
        for (int c = 1; c <= 16; c++) begin
            tick(1);
            total++;
            if (clk_ack[0] !== 1'b1 || clk_gate_en[0] !== 1'b1) begin
                bad++;
                $display("FAIL idle_hold cyc=%0d got gate=%b ack=%b exp gate=1 ack=1", c, clk_gate_en[0], clk_ack[0]);
            end
        end
        tick(1);
        total++;
        if (clk_ack !== 4'h0 || clk_gate_en !== 4'h0) begin
            bad++;
            $display("FAIL idle_fall got gate=%h ack=%h exp gate=0 ack=0", clk_gate_en, clk_ack);
        end
    endtask

    task automatic test_reassert();
        do_reset();
        global_en = 1'b1; module_en = 4'b0001;
        tick(3);
        module_en = 4'b0000;
        tick(10);
        module_en = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            total++;
            if (clk_ack[0] !== 1'b1 || clk_gate_en[0] !== 1'b1) begin
                bad++;
                $display("FAIL reassert_stay_on cyc=%0d got gate=%b ack=%b exp 1/1", c, clk_gate_en[0], clk_ack[0]);
            end
        end
        // request returns exactly in the cycle the idle count hits zero
        module_en = 4'b0000;
        tick(16);
        module_en = 4'b0001;
        tick(1);
        total++;
        if (clk_ack[0] !== 1'b1 || clk_gate_en[0] !== 1'b1) begin
            bad++;
            $display("FAIL reassert_at_zero got gate=%b ack=%b exp 1/1", clk_gate_en[0], clk_ack[0]);
        end
        tick(20);
        total++;
        if (clk_ack[0] !== 1'b1) begin
            bad++;
            $display("FAIL reassert_at_zero_steady got=%b exp=1", clk_ack[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        global_en = 1'b1; module_en = 4'b0011;
        tick(3);
        module_en = 4'b0000;
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (clk_gate_en !== 4'h0 || clk_ack !== 4'h0) begin
            bad++;
            $display("FAIL async_reset got gate=%h ack=%h exp gate=0 ack=0", clk_gate_en, clk_ack);
        end
        do_reset();
    endtask

    task automatic test_external();
        do_reset();
        external_en = 4'b1000; module_en = 4'b0100;
        tick(1);
        total++;
        if (clk_gate_en !== 4'b1000) begin
            bad++;
            $display("FAIL ext_gate got=%h exp=8", clk_gate_en);
        end
        tick(2);
        total++;
        if (clk_ack !== 4'b1000 || clk_gate_en !== 4'b1000) begin
            bad++;
            $display("FAIL ext_ack got gate=%h ack=%h exp gate=8 ack=8", clk_gate_en, clk_ack);
        end
        local_en = 4'b0010;
        tick(3);
        total++;
        if (clk_gate_en !== 4'b1000) begin
            bad++;
            $display("FAIL local_without_global got=%h exp=8", clk_gate_en);
        end
        do_reset();
    endtask

    task automatic test_se();
        for (int m = 0; m < 2; m++) begin
            do_reset();
            if (m == 0) pad_yy_test_mode = 1'b1;
            else        pad_yy_gate_clk_en_b = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick(1);
                total++;
                if (clk_out !== 4'hF) begin
                    bad++;
                    $display("FAIL se_clk_high mode=%0d got=%h exp=f", m, clk_out);
                end
                @(negedge clk_in); #1;
                total++;
                if (clk_out !== 4'h0) begin
                    bad++;
                    $display("FAIL se_clk_low mode=%0d got=%h exp=0", m, clk_out);
                end
                total++;
                if (clk_gate_en !== 4'h0 || clk_ack !== 4'h0) begin
                    bad++;
                    $display("FAIL se_state mode=%0d got gate=%h ack=%h exp 0/0", m, clk_gate_en, clk_ack);
                end
            end
        end
        pad_yy_test_mode = 1'b0; pad_yy_gate_clk_en_b = 1'b0;
        tick(2);
        total++;
        if (clk_out !== 4'h0) begin
            bad++;
            $display("FAIL se_release got=%h exp=0", clk_out);
        end
    endtask

    task automatic test_zero_cyc();
        do_reset();
        global_en = 1'b1; module_en = 4'b0001;
        tick(1);
        module_en = 4'b0000;
        total++;
        if (z_clk_gate_en !== 4'b0001 || z_clk_ack !== 4'b0001) begin
            bad++;
            $display("FAIL zero_on got gate=%h ack=%h exp 1/1", z_clk_gate_en, z_clk_ack);
        end
        tick(1);
        total++;
        if (z_clk_gate_en !== 4'h0 || z_clk_ack !== 4'h0) begin
            bad++;
            $display("FAIL zero_off got gate=%h ack=%h exp 0/0", z_clk_gate_en, z_clk_ack);
        end
    endtask

    task automatic test_wake_drop();
        logic [1:0] exp_ga [1:8];
        // {gate,ack} after each edge; request dropped right after the first
        exp_ga[1] = 2'b10; exp_ga[2] = 2'b10; exp_ga[3] = 2'b10; exp_ga[4] = 2'b11;
        exp_ga[5] = 2'b11; exp_ga[6] = 2'b11; exp_ga[7] = 2'b11; exp_ga[8] = 2'b11;
        do_reset();
        global_en = 1'b1; module_en = 4'b0001;
        tick(1);
        module_en = 4'b0000;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick(1);
            total++;
            if ({w_clk_gate_en[0], w_clk_ack[0]} !== exp_ga[c]) begin
                bad++;
                $display("FAIL wake_drop cyc=%0d got gate/ack=%b%b exp=%b", c, w_clk_gate_en[0], w_clk_ack[0], exp_ga[c]);
            end
        end
        tick(1);
        total++;
        if (w_clk_gate_en !== 4'h0 || w_clk_ack !== 4'h0) begin
            bad++;
            $display("FAIL wake_drop_off got gate=%h ack=%h exp 0/0", w_clk_gate_en, w_clk_ack);
        end
    endtask

    initial begin
        test_reset();
        test_wake();
        test_idle();
        test_reassert();
        test_async_reset();
        test_external();
        test_se();
        test_zero_cyc();
        test_wake_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
